// File: rtl/touch_gesture_if.sv
// Touch front-end bundle: coordinate stream and zone table in, gesture/slider events out.
interface touch_gesture_if #(
    parameter int unsigned COORD_W = 8,
    parameter int unsigned N_ZONES = 8
);
    localparam int unsigned ZW = $clog2(N_ZONES + 1);

    logic [COORD_W-1:0]           x_in;
    logic [COORD_W-1:0]           y_in;
    logic                         coord_valid;
    logic                         penirq_n;
    logic [N_ZONES*4*COORD_W-1:0] zone_rect;
    logic                         slide_load;
    logic [7:0]                   slide_load_val;

    logic [COORD_W-1:0]           hit_x;
    logic [COORD_W-1:0]           hit_y;
    logic [ZW-1:0]                zone_id;
    logic                         press_pulse;
    logic                         release_pulse;
    logic                         drag_active;
    logic [7:0]                   slide_val;
    logic                         write_slide;

    modport master (
        output x_in, y_in, coord_valid, penirq_n, zone_rect, slide_load, slide_load_val,
        input  hit_x, hit_y, zone_id, press_pulse, release_pulse, drag_active, slide_val,
               write_slide
    );

    modport slave (
        input  x_in, y_in, coord_valid, penirq_n, zone_rect, slide_load, slide_load_val,
        output hit_x, hit_y, zone_id, press_pulse, release_pulse, drag_active, slide_val,
               write_slide
    );
endinterface

// File: rtl/touch_gesture_decoder.sv
// Touch gesture decoder: pen debounce, press-point latch, zone hit test, press/release/drag
// events and a saturating slider value driven by a bar zone and +/- zones with auto-repeat.
module touch_gesture_decoder #(
    parameter int unsigned COORD_W    = 8,
    parameter int unsigned N_ZONES    = 8,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned DRAG_THR   = 3,
    parameter int unsigned SLIDE_ZONE = 0,
    parameter int unsigned MINUS_ZONE = 1,
    parameter int unsigned PLUS_ZONE  = 2,
    parameter int unsigned SLIDE_MAX  = 127,
    parameter int unsigned HOLD_CYC   = 2**20,
    parameter int unsigned REPEAT_CYC = 2**18
) (
    input logic          sys_clk,
    input logic          iRST_n,
    touch_gesture_if.slave bus
);
    localparam int unsigned ZW = $clog2(N_ZONES + 1);
    localparam int unsigned DW = $clog2(DEBOUNCE + 1);
    localparam int unsigned RW = $clog2(HOLD_CYC + REPEAT_CYC + 1);
    localparam int unsigned PW = COORD_W + 8;

    typedef enum logic [2:0] {StIdle, StDebounce, StZone, StPressed, StDrag} state_e;

    state_e             state_q, state_d;
    logic [1:0]         pen_sync;
    logic               pen_down;
    logic [DW-1:0]      deb_cnt_q, deb_cnt_d;
    logic [COORD_W-1:0] hit_x_q, hit_x_d, hit_y_q, hit_y_d;
    logic [ZW-1:0]      zone_q, zone_d, zone_hit;
    logic               press_q, press_d, release_q, release_d, drag_q, drag_d;
    logic [7:0]         slide_q, slide_d, touch_val, dec_val, inc_val;
    logic               write_q, write_d, touch_upd;
    logic [RW-1:0]      rep_cnt_q, rep_cnt_d;
    logic               rep_phase_q, rep_phase_d, rep_step;
    logic [COORD_W-1:0] zx0, zx1, zy0, zy1, sx0, sx1, dx, dy;
    logic               is_minus, is_plus, is_slide;

    // Map x onto 0..SLIDE_MAX across [lo,hi], clamping x into the bar first.
    function automatic logic [7:0] scale(input logic [COORD_W-1:0] x, lo, hi);
        logic [COORD_W-1:0] xc;
        logic [PW-1:0]      num, quo;
        if (hi <= lo) return 8'(SLIDE_MAX);
        xc  = (x < lo) ? lo : ((x > hi) ? hi : x);
        num = PW'(xc - lo) * PW'(SLIDE_MAX);
        quo = num / PW'(hi - lo);
        return quo[7:0];
    endfunction

    assign sx0      = bus.zone_rect[SLIDE_ZONE*4*COORD_W + 3*COORD_W +: COORD_W];
    assign sx1      = bus.zone_rect[SLIDE_ZONE*4*COORD_W + 2*COORD_W +: COORD_W];
    assign pen_down = ~pen_sync[1];
    assign dx       = (bus.x_in >= hit_x_q) ? bus.x_in - hit_x_q : hit_x_q - bus.x_in;
    assign dy       = (bus.y_in >= hit_y_q) ? bus.y_in - hit_y_q : hit_y_q - bus.y_in;
    assign is_minus = (zone_q == ZW'(MINUS_ZONE));
    assign is_plus  = (zone_q == ZW'(PLUS_ZONE));
    assign is_slide = (zone_q == ZW'(SLIDE_ZONE));
    assign dec_val  = (slide_q == 8'd0) ? 8'd0 : slide_q - 8'd1;
    assign inc_val  = (slide_q >= 8'(SLIDE_MAX)) ? 8'(SLIDE_MAX) : slide_q + 8'd1;

    // Hit test of the latched point; scanning downwards lets the lowest index win.
    always_comb begin
        zone_hit = ZW'(N_ZONES);
        zx0 = '0; zx1 = '0; zy0 = '0; zy1 = '0;
        for (int i = N_ZONES - 1; i >= 0; i--) begin
            zx0 = bus.zone_rect[i*4*COORD_W + 3*COORD_W +: COORD_W];
            zx1 = bus.zone_rect[i*4*COORD_W + 2*COORD_W +: COORD_W];
            zy0 = bus.zone_rect[i*4*COORD_W + 1*COORD_W +: COORD_W];
            zy1 = bus.zone_rect[i*4*COORD_W +: COORD_W];
            if (hit_x_q >= zx0 && hit_x_q <= zx1 && hit_y_q >= zy0 && hit_y_q <= zy1)
                zone_hit = ZW'(i);
        end
    end

    // Gesture FSM next-state and event pulses.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        hit_x_d   = hit_x_q;
        hit_y_d   = hit_y_q;
        zone_d    = zone_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        drag_d    = drag_q;
        unique case (state_q)
            StIdle: begin
                if (pen_down) begin
                    state_d   = StDebounce;
                    deb_cnt_d = '0;
                end
            end
            StDebounce: begin
                if (!pen_down) begin
                    state_d = StIdle;
                end else if (bus.coord_valid) begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                    if (deb_cnt_q == DW'(DEBOUNCE - 1)) begin
                        hit_x_d = bus.x_in;
                        hit_y_d = bus.y_in;
                        state_d = StZone;
                    end
                end
            end
            StZone: begin
                zone_d  = zone_hit;
                press_d = 1'b1;
                state_d = StPressed;
            end
            StPressed: begin
                if (!pen_down) begin
                    release_d = 1'b1;
                    state_d   = StIdle;
                end else if (bus.coord_valid &&
                             (dx >= COORD_W'(DRAG_THR) || dy >= COORD_W'(DRAG_THR))) begin
                    drag_d  = 1'b1;
                    state_d = StDrag;
                end
            end
            StDrag: begin
                if (!pen_down) begin
                    release_d = 1'b1;
                    drag_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Slider: press actions, drag re-scaling, +/- auto-repeat; an external load wins.
    always_comb begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
        rep_step    = 1'b0;
        touch_upd   = 1'b0;
        touch_val   = slide_q;
        slide_d     = slide_q;
        write_d     = 1'b0;
        if (state_q == StPressed && (is_minus || is_plus)) begin
            rep_phase_d = rep_phase_q;
            rep_cnt_d   = rep_cnt_q + 1'b1;
            if ((!rep_phase_q && rep_cnt_q == RW'(HOLD_CYC - 1)) ||
                (rep_phase_q && rep_cnt_q == RW'(REPEAT_CYC - 1))) begin
                rep_step    = 1'b1;
                rep_cnt_d   = '0;
                rep_phase_d = 1'b1;
            end
        end
        if (press_q) begin
            if (is_slide) begin
                touch_upd = 1'b1;
                touch_val = scale(hit_x_q, sx0, sx1);
            end else if (is_minus) begin
                touch_upd = 1'b1;
                touch_val = dec_val;
            end else if (is_plus) begin
                touch_upd = 1'b1;
                touch_val = inc_val;
            end
        end else if (rep_step) begin
            touch_upd = 1'b1;
            touch_val = is_minus ? dec_val : inc_val;
        end else if (state_q == StDrag && is_slide && bus.coord_valid) begin
            touch_upd = 1'b1;
            touch_val = scale(bus.x_in, sx0, sx1);
        end
        if (bus.slide_load) begin
            slide_d = (bus.slide_load_val > 8'(SLIDE_MAX)) ? 8'(SLIDE_MAX) : bus.slide_load_val;
        end else if (touch_upd && touch_val != slide_q) begin
            slide_d = touch_val;
            write_d = 1'b1;
        end
    end

    // State registers with synchronous reset; pen line passes through a 2-flop synchroniser.
    always_ff @(posedge sys_clk) begin
        if (!iRST_n) begin
            pen_sync    <= 2'b11;
            state_q     <= StIdle;
            deb_cnt_q   <= '0;
            hit_x_q     <= '0;
            hit_y_q     <= '0;
            zone_q      <= ZW'(N_ZONES);
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            drag_q      <= 1'b0;
            slide_q     <= 8'd0;
            write_q     <= 1'b0;
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            pen_sync    <= {pen_sync[0], bus.penirq_n};
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            hit_x_q     <= hit_x_d;
            hit_y_q     <= hit_y_d;
            zone_q      <= zone_d;
            press_q     <= press_d;
            release_q   <= release_d;
            drag_q      <= drag_d;
            slide_q     <= slide_d;
            write_q     <= write_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    assign bus.hit_x         = hit_x_q;
    assign bus.hit_y         = hit_y_q;
    assign bus.zone_id       = zone_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.drag_active   = drag_q;
    assign bus.slide_val     = slide_q;
    assign bus.write_slide   = write_q;
endmodule
